// File: rtl/issue_replay_buffer_pkg.sv
// Shared ID-stage types for the issue/replay buffer: the ID/EX packet,
// forwarding-select encoding, the NOP packet constant and small helpers.
`ifndef ISSUE_REPLAY_BUFFER_PKG_SV
`define ISSUE_REPLAY_BUFFER_PKG_SV

package issue_replay_buffer_pkg;

    // Issue width; fixed because rollback is encoded as 0..WAYS in 2 bits.
    localparam int WAYS           = 3;
    localparam int RB_W           = 2;
    localparam int DEFAULT_PERF_W = 32;

    // Operand source chosen by the hazard-detection unit.
    typedef enum logic [1:0] {
        RS_REGFILE = 2'd0,
        RS_EX_FWD  = 2'd1,
        RS_MEM_FWD = 2'd2,
        RS_WB_FWD  = 2'd3
    } RS_SELECT;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        RS_SELECT    rs1_select;
        RS_SELECT    rs2_select;
    } ID_EX_PACKET;

    // Bubble: invalid way carrying a canonical addi x0,x0,0 encoding.
    localparam ID_EX_PACKET NOP_ID_EX_PACKET = '{
        valid:      1'b0,
        pc:         32'h0000_0000,
        inst:       32'h0000_0013,
        rd:         5'd0,
        rs1_select: RS_REGFILE,
        rs2_select: RS_REGFILE
    };

    // True when at least one way of a bundle holds a real instruction.
    function automatic logic any_valid(input ID_EX_PACKET bundle [WAYS]);
        logic found;
        found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            found = found | bundle[i].valid;
        end
        return found;
    endfunction

endpackage

`endif

// File: rtl/issue_replay_buffer_shifter.sv
// Combinational way selector: masks the annotated bundle down to the ways
// that may issue this cycle and packs the rolled-back ways into the lowest
// slots so they replay next cycle in their original order.
`ifndef ISSUE_REPLAY_BUFFER_SHIFTER_SV
`define ISSUE_REPLAY_BUFFER_SHIFTER_SV

module bundle_shifter
    import issue_replay_buffer_pkg::*;
(
    input  ID_EX_PACKET      det_bundle   [WAYS],
    input  ID_EX_PACKET      cur_bundle   [WAYS],
    input  logic [RB_W-1:0]  rollback,
    output ID_EX_PACKET      issue_bundle [WAYS],
    output ID_EX_PACKET      rem_bundle   [WAYS]
);

    // Issue the oldest WAYS-rollback ways; shift the youngest rollback ways down.
    always_comb begin
        // NOTE: every output gets a default first so no branch of the case
        // leaves one unassigned and infers a latch.
        for (int i = 0; i < WAYS; i++) begin
            issue_bundle[i] = NOP_ID_EX_PACKET;
            rem_bundle[i]   = NOP_ID_EX_PACKET;
        end
        case (rollback)
            2'd0: begin
                for (int i = 0; i < WAYS; i++) begin
                    issue_bundle[i] = det_bundle[i];
                end
            end
            2'd1: begin
                issue_bundle[0] = det_bundle[0];
                issue_bundle[1] = det_bundle[1];
                rem_bundle[0]   = cur_bundle[2];
            end
            2'd2: begin
                issue_bundle[0] = det_bundle[0];
                rem_bundle[0]   = cur_bundle[1];
                rem_bundle[1]   = cur_bundle[2];
            end
            default: begin
                // Full stall: nothing issues, the whole bundle is retained.
                for (int i = 0; i < WAYS; i++) begin
                    rem_bundle[i] = cur_bundle[i];
                end
            end
        endcase
    end

endmodule

`endif

// File: rtl/issue_replay_buffer.sv
// Holds the decoded 3-way bundle in ID, issues the ways the hazard unit
// allows, replays the rolled-back remainder and back-pressures decode until
// the bundle has fully drained. Also counts replay cycles for perf.
`ifndef ISSUE_REPLAY_BUFFER_SV
`define ISSUE_REPLAY_BUFFER_SV

module issue_replay_buffer
    import issue_replay_buffer_pkg::*;
#(
    parameter int PERF_W = DEFAULT_PERF_W
) (
    input  logic              clock,
    input  logic              reset,
    input  ID_EX_PACKET       dec_packet   [WAYS],
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic              squash,
    output ID_EX_PACKET       cur_packet   [WAYS],
    input  ID_EX_PACKET       det_packet   [WAYS],
    input  logic [RB_W-1:0]   rollback,
    output ID_EX_PACKET       issue_packet [WAYS],
    output logic [PERF_W-1:0] replay_cycles
);

    ID_EX_PACKET cur_q [WAYS];
    ID_EX_PACKET rem   [WAYS];

    bundle_shifter u_shifter (
        .det_bundle   (det_packet),
        .cur_bundle   (cur_q),
        .rollback     (rollback),
        .issue_bundle (issue_packet),
        .rem_bundle   (rem)
    );

    assign cur_packet = cur_q;

    // Accept a new bundle only once nothing valid is left to replay.
    assign dec_ready = !squash && !any_valid(rem);

    // Bundle register and replay counter; reset > squash > accept > drain > replay.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every update here sees the
        // pre-edge values of cur_q and replay_cycles.
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                cur_q[i] <= NOP_ID_EX_PACKET;
            end
            replay_cycles <= '0;
        end else begin
            if (squash) begin
                for (int i = 0; i < WAYS; i++) begin
                    cur_q[i] <= NOP_ID_EX_PACKET;
                end
            end else if (dec_ready && dec_valid) begin
                cur_q <= dec_packet;
            end else if (dec_ready) begin
                for (int i = 0; i < WAYS; i++) begin
                    cur_q[i] <= NOP_ID_EX_PACKET;
                end
            end else begin
                cur_q <= rem;
            end

            if (!squash && (rollback != '0) && any_valid(cur_q)) begin
                replay_cycles <= replay_cycles + PERF_W'(1);
            end
        end
    end

endmodule

`endif

// File: tb/tb_issue_replay_buffer.sv
// Bench for issue_replay_buffer: directed cycle table for the documented
// corner cases, then randomized bundles/rollback against a queue-based model
// and an in-order issue scoreboard.
module tb_issue_replay_buffer;
    import issue_replay_buffer_pkg::*;

    typedef ID_EX_PACKET [WAYS-1:0] bundle_t;
    localparam int BW = $bits(bundle_t);

    typedef struct {
        logic        rst;
        logic        sq;
        logic        dv;
        logic [1:0]  rb;
        bundle_t     dec;
        bundle_t     e_cur;
        bundle_t     e_iss;
        logic        e_rdy;
        int unsigned e_rep;
    } vec_t;

    localparam int NROWS = 16;
    localparam int NRAND = 400;

    logic              clock = 1'b0;
    logic              reset;
    logic              dec_valid;
    logic              dec_ready;
    logic              squash;
    logic [RB_W-1:0]   rollback;
    logic [31:0]       replay_cycles;
    ID_EX_PACKET       dec_packet   [WAYS];
    ID_EX_PACKET       cur_packet   [WAYS];
    ID_EX_PACKET       det_packet   [WAYS];
    ID_EX_PACKET       issue_packet [WAYS];

    bundle_t dec_b, cur_b, issue_b;

    int n_vec = 0;
    int n_bad = 0;

    vec_t        tbl [NROWS];
    ID_EX_PACKET pa, pb, pc_, pd, pe, pf, px, aa, ab, ac, nop;
    bundle_t     nb;

    // Random-phase model state
    bundle_t     mcur;
    ID_EX_PACKET sb [$];
    int unsigned mcnt;
    logic [31:0] pc_next;

    always #5 clock = ~clock;

    issue_replay_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .dec_packet    (dec_packet),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .squash        (squash),
        .cur_packet    (cur_packet),
        .det_packet    (det_packet),
        .rollback      (rollback),
        .issue_packet  (issue_packet),
        .replay_cycles (replay_cycles)
    );

    // Stand-in detection unit: tags valid ways with forwarding selects.
    function automatic ID_EX_PACKET ann(input ID_EX_PACKET p);
        ID_EX_PACKET r;
        r = p;
        if (p.valid) begin
            r.rs1_select = RS_EX_FWD;
            r.rs2_select = RS_MEM_FWD;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            dec_packet[i] = dec_b[i];
            cur_b[i]      = cur_packet[i];
            det_packet[i] = ann(cur_packet[i]);
            issue_b[i]    = issue_packet[i];
        end
    end

    function automatic ID_EX_PACKET mk(input logic v, input logic [31:0] pc);
        ID_EX_PACKET p;
        p       = NOP_ID_EX_PACKET;
        p.valid = v;
        p.pc    = pc;
        p.inst  = pc ^ 32'h00a0_0033;
        p.rd    = pc[6:2];
        return p;
    endfunction

    function automatic bundle_t bun(input ID_EX_PACKET p0, p1, p2);
        bundle_t b;
        b[0] = p0;
        b[1] = p1;
        b[2] = p2;
        return b;
    endfunction

    function automatic vec_t row(input logic rst, sq, dv, input logic [1:0] rb,
                                 input bundle_t dec, ec, ei,
                                 input logic er, input int unsigned rep);
        vec_t v;
        v.rst = rst; v.sq = sq; v.dv = dv; v.rb = rb; v.dec = dec;
        v.e_cur = ec; v.e_iss = ei; v.e_rdy = er; v.e_rep = rep;
        return v;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, sq, dv, input logic [1:0] rb, input bundle_t dec);
        reset     = rst;
        squash    = sq;
        dec_valid = dv;
        rollback  = rb;
        dec_b     = dec;
    endtask

    function automatic logic bundle_has_valid(input bundle_t b);
        return b[0].valid | b[1].valid | b[2].valid;
    endfunction

    initial begin
        nop = NOP_ID_EX_PACKET;
        nb  = bun(nop, nop, nop);
        pa  = mk(1'b1, 32'h100);  pb = mk(1'b1, 32'h104);  pc_ = mk(1'b1, 32'h108);
        pd  = mk(1'b1, 32'h10c);  pe = mk(1'b1, 32'h110);  pf  = mk(1'b1, 32'h114);
        px  = mk(1'b0, 32'h200);
        aa  = ann(pa);  ab = ann(pb);  ac = ann(pc_);

        //            rst   sq    dv    rb    dec                  exp cur              exp issue            rdy   rep
        tbl[0]  = row(1'b0, 1'b0, 1'b1, 2'd0, bun(pa, pb, pc_),    nb,                  nb,                  1'b1, 0);
        tbl[1]  = row(1'b0, 1'b0, 1'b1, 2'd0, bun(pa, pb, pc_),    bun(pa, pb, pc_),    bun(aa, ab, ac),     1'b1, 0);
        tbl[2]  = row(1'b0, 1'b0, 1'b1, 2'd2, bun(pd, pe, pf),     bun(pa, pb, pc_),    bun(aa, nop, nop),   1'b0, 0);
        tbl[3]  = row(1'b0, 1'b0, 1'b1, 2'd0, bun(pa, pb, pc_),    bun(pb, pc_, nop),   bun(ab, ac, nop),    1'b1, 1);
        tbl[4]  = row(1'b0, 1'b0, 1'b1, 2'd3, bun(pd, pe, pf),     bun(pa, pb, pc_),    nb,                  1'b0, 1);
        tbl[5]  = row(1'b0, 1'b0, 1'b1, 2'd3, bun(pd, pe, pf),     bun(pa, pb, pc_),    nb,                  1'b0, 2);
        tbl[6]  = row(1'b0, 1'b0, 1'b1, 2'd0, bun(pa, pb, pc_),    bun(pa, pb, pc_),    bun(aa, ab, ac),     1'b1, 3);
        tbl[7]  = row(1'b0, 1'b1, 1'b1, 2'd1, bun(pd, pe, pf),     bun(pa, pb, pc_),    bun(aa, ab, nop),    1'b0, 3);
        tbl[8]  = row(1'b0, 1'b0, 1'b1, 2'd0, bun(pa, pb, pc_),    nb,                  nb,                  1'b1, 3);
        tbl[9]  = row(1'b0, 1'b0, 1'b0, 2'd2, bun(pd, pe, pf),     bun(pa, pb, pc_),    bun(aa, nop, nop),   1'b0, 3);
        tbl[10] = row(1'b0, 1'b0, 1'b0, 2'd2, bun(pd, pe, pf),     bun(pb, pc_, nop),   bun(ab, nop, nop),   1'b0, 4);
        tbl[11] = row(1'b1, 1'b0, 1'b1, 2'd3, bun(pd, pe, pf),     bun(pc_, nop, nop),  nb,                  1'b0, 5);
        tbl[12] = row(1'b0, 1'b0, 1'b0, 2'd0, bun(pd, pe, pf),     nb,                  nb,                  1'b1, 0);
        tbl[13] = row(1'b0, 1'b0, 1'b1, 2'd2, bun(pa, px, pc_),    nb,                  nb,                  1'b1, 0);
        tbl[14] = row(1'b0, 1'b0, 1'b0, 2'd1, bun(pd, pe, pf),     bun(pa, px, pc_),    bun(aa, px, nop),    1'b0, 0);
        tbl[15] = row(1'b0, 1'b0, 1'b0, 2'd0, bun(pd, pe, pf),     bun(pc_, nop, nop),  bun(ac, nop, nop),   1'b1, 1);

        // Reset sequence
        drive(1'b1, 1'b0, 1'b0, 2'd0, nb);
        repeat (2) @(posedge clock);

        // Directed cycle table
        for (int i = 0; i < NROWS; i++) begin
            @(negedge clock);
            drive(tbl[i].rst, tbl[i].sq, tbl[i].dv, tbl[i].rb, tbl[i].dec);
            #1;
            check($sformatf("row%0d cur", i),    cur_b,   tbl[i].e_cur);
            check($sformatf("row%0d issue", i),  issue_b, tbl[i].e_iss);
            check($sformatf("row%0d ready", i),  BW'(dec_ready), BW'(tbl[i].e_rdy));
            check($sformatf("row%0d replay", i), BW'(replay_cycles), BW'(tbl[i].e_rep));
        end

        // Hand-written sequence: reset from a loaded state, then random phase
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b1, 2'd0, bun(pa, pb, pc_));
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 2'd0, nb);
        #1;
        check("post-reset cur", cur_b, nb);
        check("post-reset replay", BW'(replay_cycles), BW'(0));

        mcur    = nb;
        mcnt    = 0;
        pc_next = 32'h1000;
        sb.delete();

        for (int cyc = 0; cyc < NRAND; cyc++) begin
            logic [1:0]  rb;
            logic        sq, dv, e_rdy;
            bundle_t     dec, e_iss, nxt;
            ID_EX_PACKET rest [$];
            int          n;

            @(negedge clock);
            rb = 2'($urandom_range(0, 3));
            sq = ($urandom_range(0, 19) == 0);
            dv = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < WAYS; w++) begin
                dec[w]  = mk($urandom_range(0, 3) != 0, pc_next);
                pc_next = pc_next + 32'd4;
            end
            drive(1'b0, sq, dv, rb, dec);
            #1;

            // Oldest n ways issue; the rest slide down, padded with bubbles.
            n = WAYS - int'(rb);
            rest.delete();
            for (int w = 0; w < WAYS; w++) begin
                e_iss[w] = (w < n) ? ann(mcur[w]) : nop;
                if (w >= n) rest.push_back(mcur[w]);
            end
            while (rest.size() < WAYS) rest.push_back(nop);
            for (int w = 0; w < WAYS; w++) nxt[w] = rest[w];
            e_rdy = !sq && !bundle_has_valid(nxt);

            check($sformatf("rnd%0d cur", cyc),    cur_b,   mcur);
            check($sformatf("rnd%0d issue", cyc),  issue_b, e_iss);
            check($sformatf("rnd%0d ready", cyc),  BW'(dec_ready), BW'(e_rdy));
            check($sformatf("rnd%0d replay", cyc), BW'(replay_cycles), BW'(mcnt));

            // In-order, exactly-once issue of every accepted valid way
            for (int w = 0; w < WAYS; w++) begin
                if (issue_b[w].valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL rnd%0d sb: unexpected issue pc %h, expected none", cyc, issue_b[w].pc);
                    end else begin
                        ID_EX_PACKET e;
                        e = sb.pop_front();
                        check($sformatf("rnd%0d sb pc", cyc), BW'(issue_b[w].pc), BW'(e.pc));
                    end
                end
            end

            if (!sq && rb != 2'd0 && bundle_has_valid(mcur)) mcnt++;
            if (sq) begin
                mcur = nb;
                sb.delete();
            end else if (e_rdy && dv) begin
                mcur = dec;
                for (int w = 0; w < WAYS; w++) begin
                    if (dec[w].valid) sb.push_back(dec[w]);
                end
            end else if (e_rdy) begin
                mcur = nb;
            end else begin
                mcur = nxt;
            end
        end

        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 2'd0, nb);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
